// File: rtl/router_fsm_nch_if.sv
// Signal bundle between the router input stage and the N-channel control FSM.
// The master side is the surrounding datapath; the slave side is the FSM.
interface router_fsm_nch_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned ADDR_W = 2
);
  logic              pkt_valid;
  logic [ADDR_W-1:0] data_in;
  logic              parity_done;
  logic              low_pkt_valid;
  logic              fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] sft_rst;

  logic [NUM_CH-1:0] dest_sel;
  logic              busy;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              write_enb_reg;
  logic              rst_int_reg;
  logic              drop_state;
  logic              addr_err;
  logic              wait_timeout;

  modport master (
    output pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full,
           fifo_empty, sft_rst,
    input  dest_sel, busy, detect_add, lfd_state, ld_state, laf_state,
           full_state, write_enb_reg, rst_int_reg, drop_state, addr_err,
           wait_timeout
  );

  modport slave (
    input  pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full,
           fifo_empty, sft_rst,
    output dest_sel, busy, detect_add, lfd_state, ld_state, laf_state,
           full_state, write_enb_reg, rst_int_reg, drop_state, addr_err,
           wait_timeout
  );
endinterface

// File: rtl/router_fsm_nch.sv
// Router input-side control FSM for NUM_CH output channels: decodes the header
// address, sequences header/payload/parity writes, handles FIFO-full stalls,
// soft resets, invalid addresses and a bounded wait for a busy destination.
module router_fsm_nch #(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic               clk,
  input  logic               rstn,
  router_fsm_nch_if.slave    bus
);

  localparam logic [3:0] DECODE_ADDR        = 4'd0;
  localparam logic [3:0] LOAD_FIRST_DATA    = 4'd1;
  localparam logic [3:0] LOAD_DATA          = 4'd2;
  localparam logic [3:0] LOAD_PARITY        = 4'd3;
  localparam logic [3:0] CHECK_PARITY_ERROR = 4'd4;
  localparam logic [3:0] FIFO_FULL_STATE    = 4'd5;
  localparam logic [3:0] LOAD_AFTER_FULL    = 4'd6;
  localparam logic [3:0] WAIT_TILL_EMPTY    = 4'd7;
  localparam logic [3:0] DROP_PKT           = 4'd8;

  localparam int unsigned    CNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  logic [3:0]        state, next_state;
  logic [NUM_CH-1:0] dest_q, dest_d;
  logic [NUM_CH-1:0] hdr_onehot;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_d;
  logic              addr_ok;
  logic              hdr_empty;
  logic              sel_empty;
  logic              sel_sft;
  logic              addr_err_c;
  logic              timeout_c;

  // Header address decode; the latched one-hot destination doubles as the
  // channel selector, so no out-of-range indexing ever happens.
  always_comb begin
    hdr_onehot = '0;
    addr_ok    = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (bus.data_in == ADDR_W'(i)) begin
        hdr_onehot[i] = 1'b1;
        addr_ok       = 1'b1;
      end
    end
    hdr_empty = |(hdr_onehot & bus.fifo_empty);
    sel_empty = |(dest_q & bus.fifo_empty);
    sel_sft   = |(dest_q & bus.sft_rst);
  end

  // Next-state, destination, wait counter and event pulses.
  always_comb begin
    next_state = state;
    dest_d     = dest_q;
    wait_cnt_d = wait_cnt;
    addr_err_c = 1'b0;
    timeout_c  = 1'b0;
    case (state)
      DECODE_ADDR: begin
        if (bus.pkt_valid) begin
          dest_d = hdr_onehot;
          if (!addr_ok) begin
            next_state = DROP_PKT;
            addr_err_c = 1'b1;
          end else if (hdr_empty) begin
            next_state = LOAD_FIRST_DATA;
          end else begin
            next_state = WAIT_TILL_EMPTY;
            wait_cnt_d = '0;
          end
        end
      end
      LOAD_FIRST_DATA: next_state = LOAD_DATA;
      LOAD_DATA: begin
        if (bus.fifo_full)       next_state = FIFO_FULL_STATE;
        else if (!bus.pkt_valid) next_state = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!bus.fifo_full) next_state = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (bus.parity_done)        next_state = DECODE_ADDR;
        else if (bus.low_pkt_valid) next_state = LOAD_PARITY;
        else                        next_state = LOAD_DATA;
      end
      LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        next_state = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDR;
      end
      WAIT_TILL_EMPTY: begin
        if (sel_empty) begin
          next_state = LOAD_FIRST_DATA;
        end else if (wait_cnt == CNT_LAST) begin
          next_state = DROP_PKT;
          timeout_c  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt + 1'b1;
        end
      end
      DROP_PKT: begin
        if (!bus.pkt_valid) next_state = DECODE_ADDR;
      end
      default: next_state = DECODE_ADDR;
    endcase

    // Soft reset of the selected channel overrides every other transition,
    // including a pending timeout, so that pulse is suppressed as well.
    if (state != DECODE_ADDR && state != DROP_PKT && sel_sft) begin
      next_state = DECODE_ADDR;
      timeout_c  = 1'b0;
    end

    if (next_state == DECODE_ADDR) dest_d = '0;
  end

  // State, destination and wait counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= DECODE_ADDR;
      dest_q   <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      dest_q   <= dest_d;
      wait_cnt <= wait_cnt_d;
    end
  end

  assign bus.dest_sel      = dest_q;
  assign bus.detect_add    = (state == DECODE_ADDR);
  assign bus.lfd_state     = (state == LOAD_FIRST_DATA);
  assign bus.ld_state      = (state == LOAD_DATA);
  assign bus.laf_state     = (state == LOAD_AFTER_FULL);
  assign bus.full_state    = (state == FIFO_FULL_STATE);
  assign bus.drop_state    = (state == DROP_PKT);
  assign bus.write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                             (state == LOAD_AFTER_FULL);
  assign bus.rst_int_reg   = (state == CHECK_PARITY_ERROR);
  assign bus.busy          = !((state == DECODE_ADDR) || (state == LOAD_DATA) ||
                               (state == DROP_PKT));
  assign bus.addr_err      = addr_err_c;
  assign bus.wait_timeout  = timeout_c;

endmodule

// File: tb/tb_router_fsm_nch.sv
// Scoreboard bench for router_fsm_nch: a driver issues per-cycle stimulus and
// queues the expected outputs from a behavioural packet model; a monitor pops
// and compares just before each rising edge.
module tb_router_fsm_nch;
  localparam int unsigned NC = 3;
  localparam int unsigned AW = 2;
  localparam int unsigned WM = 4;
  localparam int unsigned OW = NC + 11;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  router_fsm_nch_if #(.NUM_CH(NC), .ADDR_W(AW)) bus ();

  router_fsm_nch #(.NUM_CH(NC), .ADDR_W(AW), .WAIT_MAX(WM)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [OW-1:0] exp_q[$];

  // Model: named phase of the packet, chosen channel (-1 = none), WAIT cycles used.
  string st     = "DECODE";
  int    dest   = -1;
  int    waited = 0;

  task automatic cyc(input bit rst, input bit pv, input int d, input bit pd,
                     input bit lpv, input bit ff,
                     input logic [NC-1:0] fe, input logic [NC-1:0] sr);
    logic [OW-1:0]  e;
    logic [NC-1:0]  ds;
    bit    a_err, t_out, sel_e, sel_s, bsy;
    string nx;
    @(negedge clk);
    rstn              = !rst;
    bus.pkt_valid     = pv;
    bus.data_in       = AW'(d);
    bus.parity_done   = pd;
    bus.low_pkt_valid = lpv;
    bus.fifo_full     = ff;
    bus.fifo_empty    = fe;
    bus.sft_rst       = sr;
    if (rst) begin
      st = "DECODE"; dest = -1; waited = 0;
    end
    sel_e = (dest >= 0) && fe[dest];
    sel_s = (dest >= 0) && sr[dest];
    ds    = (dest >= 0) ? NC'(1 << dest) : NC'(0);
    a_err = (st == "DECODE") && pv && (d >= NC);
    t_out = (st == "WAIT") && !sel_e && (waited == WM - 1) && !sel_s;
    bsy   = !((st == "DECODE") || (st == "DATA") || (st == "DROP"));
    e = {ds, bsy, st == "DECODE", st == "FIRST", st == "DATA", st == "AFTER",
         st == "FULL", (st == "DATA") || (st == "PARITY") || (st == "AFTER"),
         st == "CHECK", st == "DROP", a_err, t_out};
    exp_q.push_back(e);
    if (!rst) begin
      nx = st;
      if (st == "DECODE") begin
        if (pv) begin
          if (d >= NC) begin
            nx = "DROP"; dest = -1;
          end else begin
            dest = d;
            if (fe[d]) nx = "FIRST";
            else begin nx = "WAIT"; waited = 0; end
          end
        end
      end else if (st == "DROP") begin
        if (!pv) nx = "DECODE";
      end else if (sel_s) begin
        nx = "DECODE";
      end else if (st == "FIRST") nx = "DATA";
      else if (st == "DATA") begin
        if (ff) nx = "FULL";
        else if (!pv) nx = "PARITY";
      end else if (st == "FULL") begin
        if (!ff) nx = "AFTER";
      end else if (st == "AFTER") begin
        if (pd) nx = "DECODE";
        else if (lpv) nx = "PARITY";
        else nx = "DATA";
      end else if (st == "PARITY") nx = "CHECK";
      else if (st == "CHECK") nx = ff ? "FULL" : "DECODE";
      else if (st == "WAIT") begin
        if (sel_e) nx = "FIRST";
        else if (waited == WM - 1) nx = "DROP";
        else waited++;
      end
      if (nx == "DECODE") dest = -1;
      st = nx;
    end
  endtask

  // Monitor: compare every cycle just ahead of the active edge.
  initial begin
    logic [OW-1:0] e, got;
    int mcyc;
    mcyc = 0;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {bus.dest_sel, bus.busy, bus.detect_add, bus.lfd_state,
               bus.ld_state, bus.laf_state, bus.full_state, bus.write_enb_reg,
               bus.rst_int_reg, bus.drop_state, bus.addr_err, bus.wait_timeout};
        tests++;
        if (got !== e) begin
          fails++;
          $display("FAIL outputs cycle %0d: got %b required %b (dest_sel,busy,det,lfd,ld,laf,full,wen,rstint,drop,aerr,tmo)",
                   mcyc, got, e);
        end
        mcyc++;
      end
    end
  end

  initial begin
    bit rst, pv, pd, lpv, ff;
    int d;
    logic [NC-1:0] fe, sr;
    bus.pkt_valid = 0; bus.data_in = '0; bus.parity_done = 0;
    bus.low_pkt_valid = 0; bus.fifo_full = 0; bus.fifo_empty = '0; bus.sft_rst = '0;

    cyc(1, 0, 0, 0, 0, 0, 3'b000, 3'b000);
    cyc(1, 0, 0, 0, 0, 0, 3'b000, 3'b000);
    cyc(0, 0, 0, 0, 0, 0, 3'b111, 3'b000);

    // Normal packet to channel 1: header, lfd, three loads, parity, check.
    cyc(0, 1, 1, 0, 0, 0, 3'b010, 3'b000);
    cyc(0, 1, 0, 0, 0, 0, 3'b010, 3'b000);
    cyc(0, 1, 0, 0, 0, 0, 3'b000, 3'b000);
    cyc(0, 1, 0, 0, 0, 0, 3'b000, 3'b000);
    cyc(0, 0, 0, 0, 0, 0, 3'b000, 3'b000);
    cyc(0, 0, 0, 0, 0, 0, 3'b000, 3'b000);
    cyc(0, 0, 0, 0, 0, 0, 3'b000, 3'b000);
    cyc(0, 0, 0, 0, 0, 0, 3'b000, 3'b000);

    // FIFO full for two cycles mid-payload, then low_pkt_valid.
    cyc(0, 1, 0, 0, 0, 0, 3'b001, 3'b000);
    cyc(0, 1, 0, 0, 0, 0, 3'b000, 3'b000);
    cyc(0, 1, 0, 0, 0, 1, 3'b000, 3'b000);
    cyc(0, 0, 0, 0, 1, 1, 3'b000, 3'b000);
    cyc(0, 0, 0, 0, 1, 0, 3'b000, 3'b000);
    cyc(0, 0, 0, 0, 1, 0, 3'b000, 3'b000);
    cyc(0, 0, 0, 0, 0, 0, 3'b000, 3'b000);
    cyc(0, 0, 0, 0, 0, 0, 3'b000, 3'b000);
    cyc(0, 0, 0, 0, 0, 0, 3'b000, 3'b000);

    // Invalid address 3: dropped for five beats.
    cyc(0, 1, 3, 0, 0, 0, 3'b111, 3'b000);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0, 3'b111, 3'b000);
    cyc(0, 0, 0, 0, 0, 0, 3'b111, 3'b000);
    cyc(0, 0, 0, 0, 0, 0, 3'b111, 3'b000);

    // Destination 2 never empties: timeout after WM wait cycles.
    cyc(0, 1, 2, 0, 0, 0, 3'b011, 3'b000);
    for (int i = 0; i < int'(WM); i++) cyc(0, 1, 0, 0, 0, 0, 3'b011, 3'b000);
    cyc(0, 1, 0, 0, 0, 0, 3'b011, 3'b000);
    cyc(0, 0, 0, 0, 0, 0, 3'b011, 3'b000);
    cyc(0, 0, 0, 0, 0, 0, 3'b011, 3'b000);

    // Destination 2 empties after two wait cycles.
    cyc(0, 1, 2, 0, 0, 0, 3'b000, 3'b000);
    cyc(0, 1, 0, 0, 0, 0, 3'b000, 3'b000);
    cyc(0, 1, 0, 0, 0, 0, 3'b000, 3'b000);
    cyc(0, 1, 0, 0, 0, 0, 3'b100, 3'b000);
    cyc(0, 1, 0, 0, 0, 0, 3'b100, 3'b000);
    cyc(0, 0, 0, 0, 0, 0, 3'b100, 3'b000);
    cyc(0, 0, 0, 0, 0, 0, 3'b100, 3'b000);
    cyc(0, 0, 0, 0, 0, 0, 3'b100, 3'b000);

    // Empty rises exactly on the would-be timeout cycle: empty wins.
    cyc(0, 1, 2, 0, 0, 0, 3'b000, 3'b000);
    for (int i = 0; i < int'(WM) - 1; i++) cyc(0, 1, 0, 0, 0, 0, 3'b000, 3'b000);
    cyc(0, 1, 0, 0, 0, 0, 3'b100, 3'b000);
    cyc(0, 1, 0, 0, 0, 0, 3'b100, 3'b000);

    // Soft reset on the selected channel (together with fifo_full), then on
    // another channel, then async reset mid-packet.
    cyc(0, 1, 0, 0, 0, 0, 3'b100, 3'b100);
    cyc(0, 0, 0, 0, 0, 0, 3'b000, 3'b000);
    cyc(0, 1, 1, 0, 0, 0, 3'b010, 3'b000);
    cyc(0, 1, 0, 0, 0, 0, 3'b000, 3'b000);
    cyc(0, 1, 0, 0, 0, 1, 3'b000, 3'b010);
    cyc(0, 0, 0, 0, 0, 0, 3'b000, 3'b000);
    cyc(0, 1, 1, 0, 0, 0, 3'b010, 3'b000);
    cyc(0, 1, 0, 0, 0, 0, 3'b000, 3'b000);
    cyc(0, 1, 0, 0, 0, 0, 3'b000, 3'b001);
    cyc(0, 1, 0, 0, 0, 0, 3'b000, 3'b000);
    cyc(1, 0, 0, 0, 0, 0, 3'b000, 3'b000);
    cyc(0, 0, 0, 0, 0, 0, 3'b000, 3'b000);

    // Biased random traffic.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      pv  = rst ? 1'b0 : ($urandom_range(0, 9) < 8);
      d   = int'($urandom_range(0, 3));
      pd  = ($urandom_range(0, 4) == 0);
      lpv = ($urandom_range(0, 2) == 0);
      ff  = ($urandom_range(0, 4) == 0);
      for (int b = 0; b < int'(NC); b++) begin
        fe[b] = ($urandom_range(0, 9) < 4);
        sr[b] = ($urandom_range(0, 29) == 0);
      end
      cyc(rst, pv, d, pd, lpv, ff, fe, sr);
    end

    @(negedge clk);
    #4;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
